// File: rtl/btn_debounce_pkg.sv
`default_nettype none
// ============================================================================
// Module   : btn_debounce_pkg
// Brief    : Shared timing defaults, width helpers and filter-state type for
//            the multi-button debouncer.
// Revision : 1.0
// ============================================================================
package btn_debounce_pkg;

  localparam int c_DEF_TICK_DIV     = 65536;  // 2.62 ms at 25 MHz
  localparam int c_DEF_STABLE_TICKS = 4;
  localparam int c_DEF_REPEAT_DELAY = 192;
  localparam int c_DEF_REPEAT_RATE  = 38;
  localparam int c_STABLE_MAX_W     = 8;

  typedef struct packed {
    logic                      level;
    logic [c_STABLE_MAX_W-1:0] stable;
  } filt_state_t;

  function automatic int tick_w(input int div);
    return (div <= 2) ? 1 : $clog2(div);
  endfunction

  function automatic int stable_w(input int ticks);
    return (ticks <= 1) ? 1 : $clog2(ticks);
  endfunction

  function automatic int repeat_w(input int delay, input int rate);
    int m;
    m = (delay > rate) ? delay : rate;
    return $clog2(m + 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/debounce_channel.sv
`default_nettype none
// ============================================================================
// Module   : debounce_channel
// Brief    : One button channel: stable-count filter, edge pulses, optional
//            hold auto-repeat and a wrapping press counter.
// Revision : 1.0
// ============================================================================
module debounce_channel
  import btn_debounce_pkg::*;
#(
  parameter int CNT_W        = 4,
  parameter int STABLE_TICKS = c_DEF_STABLE_TICKS,
  parameter int REPEAT_EN    = 0,
  parameter int REPEAT_DELAY = c_DEF_REPEAT_DELAY,
  parameter int REPEAT_RATE  = c_DEF_REPEAT_RATE
) (
  input  logic             clk_25mhz,
  input  logic             rst_n,
  input  logic             tick,
  input  logic             s,
  input  logic             clr,
  output logic             btn_state,
  output logic             press,
  output logic             release_pulse,
  output logic [CNT_W-1:0] cnt
);

  localparam logic [c_STABLE_MAX_W-1:0] c_STABLE_LAST = c_STABLE_MAX_W'(STABLE_TICKS - 1);

  filt_state_t      r_filt;
  logic             r_press;
  logic             r_release;
  logic [CNT_W-1:0] r_cnt;

  logic w_differ;
  logic w_accept;
  logic w_rise;
  logic w_fall;
  logic w_repeat_hit;

  assign w_differ = (s != r_filt.level);
  assign w_accept = tick & w_differ & (r_filt.stable == c_STABLE_LAST);
  assign w_rise   = w_accept & ~r_filt.level;
  assign w_fall   = w_accept &  r_filt.level;

  always_ff @(posedge clk_25mhz) begin
    if (!rst_n) begin
      r_filt    <= '0;
      r_press   <= 1'b0;
      r_release <= 1'b0;
      r_cnt     <= '0;
    end else begin
      r_press   <= w_rise | w_repeat_hit;
      r_release <= w_fall;
      // A single agreeing tick throws away any partial run
      if (tick) begin
        if (!w_differ || w_accept) r_filt.stable <= '0;
        else                       r_filt.stable <= r_filt.stable + 1'b1;
        if (w_accept) r_filt.level <= ~r_filt.level;
      end
      if (clr)          r_cnt <= '0;
      else if (r_press) r_cnt <= r_cnt + 1'b1;
    end
  end

  generate
    if (REPEAT_EN != 0) begin : g_repeat
      localparam int c_RPT_W = repeat_w(REPEAT_DELAY, REPEAT_RATE);
      localparam logic [c_RPT_W-1:0] c_DELAY = c_RPT_W'(REPEAT_DELAY);
      localparam logic [c_RPT_W-1:0] c_RATE  = c_RPT_W'(REPEAT_RATE);
      localparam logic [c_RPT_W-1:0] c_ONE   = c_RPT_W'(1);

      logic [c_RPT_W-1:0] r_timer;

      // Zero means idle; a release acceptance suppresses any pending repeat
      always_ff @(posedge clk_25mhz) begin
        if (!rst_n)
          r_timer <= '0;
        else if (w_rise)
          r_timer <= c_DELAY;
        else if (w_fall)
          r_timer <= '0;
        else if (tick && r_filt.level && (r_timer != '0))
          r_timer <= (r_timer == c_ONE) ? c_RATE : r_timer - 1'b1;
      end

      assign w_repeat_hit = tick & r_filt.level & ~w_accept & (r_timer == c_ONE);
    end else begin : g_no_repeat
      assign w_repeat_hit = 1'b0;
    end
  endgenerate

  assign btn_state     = r_filt.level;
  assign press         = r_press;
  assign release_pulse = r_release;
  assign cnt           = r_cnt;

endmodule
`default_nettype wire

// File: rtl/btn_debounce_multi.sv
`default_nettype none
// ============================================================================
// Module   : btn_debounce_multi
// Brief    : Multi-button debouncer: input synchroniser, shared sample-tick
//            prescaler and one filter/counter channel per button.
// Revision : 1.0
// ============================================================================
module btn_debounce_multi
  import btn_debounce_pkg::*;
#(
  parameter int NUM_BTN      = 7,
  parameter int CNT_W        = 4,
  parameter int TICK_DIV     = c_DEF_TICK_DIV,
  parameter int STABLE_TICKS = c_DEF_STABLE_TICKS,
  parameter int REPEAT_EN    = 0,
  parameter int REPEAT_DELAY = c_DEF_REPEAT_DELAY,
  parameter int REPEAT_RATE  = c_DEF_REPEAT_RATE
) (
  input  logic                     clk_25mhz,
  input  logic                     rst_n,
  input  logic [NUM_BTN-1:0]       btn,
  input  logic [NUM_BTN-1:0]       clr,
  output logic [NUM_BTN-1:0]       btn_state,
  output logic [NUM_BTN-1:0]       press,
  // "release" is a reserved word, hence the suffix
  output logic [NUM_BTN-1:0]       release_pulse,
  output logic [NUM_BTN*CNT_W-1:0] cnt_flat
);

  localparam int                c_TICK_W    = tick_w(TICK_DIV);
  localparam logic [c_TICK_W-1:0] c_TICK_LAST = c_TICK_W'(TICK_DIV - 1);

  logic [NUM_BTN-1:0]  r_sync1;
  logic [NUM_BTN-1:0]  r_sync2;
  logic [c_TICK_W-1:0] r_presc;
  logic                w_tick;

  assign w_tick = (r_presc == c_TICK_LAST);

  always_ff @(posedge clk_25mhz) begin
    if (!rst_n) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
      r_presc <= '0;
    end else begin
      r_sync1 <= btn;
      r_sync2 <= r_sync1;
      r_presc <= w_tick ? '0 : r_presc + 1'b1;
    end
  end

  generate
    for (genvar i = 0; i < NUM_BTN; i++) begin : g_chan
      debounce_channel #(
        .CNT_W        (CNT_W),
        .STABLE_TICKS (STABLE_TICKS),
        .REPEAT_EN    (REPEAT_EN),
        .REPEAT_DELAY (REPEAT_DELAY),
        .REPEAT_RATE  (REPEAT_RATE)
      ) u_chan (
        .clk_25mhz     (clk_25mhz),
        .rst_n         (rst_n),
        .tick          (w_tick),
        .s             (r_sync2[i]),
        .clr           (clr[i]),
        .btn_state     (btn_state[i]),
        .press         (press[i]),
        .release_pulse (release_pulse[i]),
        .cnt           (cnt_flat[i*CNT_W +: CNT_W])
      );
    end
  endgenerate

endmodule
`default_nettype wire

// File: tb/tb_btn_debounce_multi.sv
`default_nettype none
// ============================================================================
// Module   : tb_btn_debounce_multi
// Brief    : Self-checking bench: a plain-repeat and an auto-repeat instance
//            driven together and compared every cycle with a tick-index model.
// Revision : 1.0
// ============================================================================
module tb_btn_debounce_multi;

  localparam int NB  = 2;
  localparam int CW  = 4;
  localparam int DIV = 4;
  localparam int ST  = 3;
  localparam int RD  = 2;
  localparam int RR  = 1;

  logic              clk_25mhz = 1'b0;
  logic              rst_n;
  logic [NB-1:0]     btn;
  logic [NB-1:0]     clr;
  logic [NB-1:0]     st0, pr0, rl0, st1, pr1, rl1;
  logic [NB*CW-1:0]  cf0, cf1;

  always #20 clk_25mhz = ~clk_25mhz;

  btn_debounce_multi #(
    .NUM_BTN(NB), .CNT_W(CW), .TICK_DIV(DIV), .STABLE_TICKS(ST),
    .REPEAT_EN(0), .REPEAT_DELAY(RD), .REPEAT_RATE(RR)
  ) dut (
    .clk_25mhz(clk_25mhz), .rst_n(rst_n), .btn(btn), .clr(clr),
    .btn_state(st0), .press(pr0), .release_pulse(rl0), .cnt_flat(cf0)
  );

  btn_debounce_multi #(
    .NUM_BTN(NB), .CNT_W(CW), .TICK_DIV(DIV), .STABLE_TICKS(ST),
    .REPEAT_EN(1), .REPEAT_DELAY(RD), .REPEAT_RATE(RR)
  ) dut_r (
    .clk_25mhz(clk_25mhz), .rst_n(rst_n), .btn(btn), .clr(clr),
    .btn_state(st1), .press(pr1), .release_pulse(rl1), .cnt_flat(cf1)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int get_st(input int d, input int ch);
    return (d == 0) ? int'(st0[ch]) : int'(st1[ch]);
  endfunction
  function automatic int get_pr(input int d, input int ch);
    return (d == 0) ? int'(pr0[ch]) : int'(pr1[ch]);
  endfunction
  function automatic int get_rl(input int d, input int ch);
    return (d == 0) ? int'(rl0[ch]) : int'(rl1[ch]);
  endfunction
  function automatic int get_cnt(input int d, input int ch);
    logic [NB*CW-1:0] v;
    v = (d == 0) ? cf0 : cf1;
    return int'(v[ch*CW +: CW]);
  endfunction

  // Model: a new level is accepted once ST ticks have passed since the last
  // tick that agreed with the current level; repeats fall at fixed tick
  // offsets from the accepted press.
  bit h1 [NB];
  bit h2 [NB];
  int n_cyc;
  int tick_idx;
  int e_state [2][NB];
  int e_press [2][NB];
  int e_rel   [2][NB];
  int e_cnt   [2][NB];
  int agree   [2][NB];
  int acc     [2][NB];

  always @(posedge clk_25mhz) begin : model
    bit tk;
    bit s;
    bit accept;
    int np, nr, dd;
    if (!rst_n) begin
      n_cyc = 0;
      tick_idx = 0;
      for (int ch = 0; ch < NB; ch++) begin
        h1[ch] = 1'b0;
        h2[ch] = 1'b0;
        for (int d = 0; d < 2; d++) begin
          e_state[d][ch] = 0; e_press[d][ch] = 0; e_rel[d][ch] = 0;
          e_cnt[d][ch] = 0;   agree[d][ch] = 0;   acc[d][ch] = -1;
        end
      end
    end else begin
      tk = ((n_cyc % DIV) == DIV - 1);
      if (tk) tick_idx++;
      for (int d = 0; d < 2; d++) begin
        for (int ch = 0; ch < NB; ch++) begin
          if (clr[ch]) e_cnt[d][ch] = 0;
          else if (e_press[d][ch] != 0) e_cnt[d][ch] = (e_cnt[d][ch] + 1) % (1 << CW);
          np = 0;
          nr = 0;
          if (tk) begin
            s = h2[ch];
            accept = (int'(s) != e_state[d][ch]) && (tick_idx - agree[d][ch] >= ST);
            if (int'(s) == e_state[d][ch]) agree[d][ch] = tick_idx;
            if (accept) begin
              e_state[d][ch] = int'(s);
              agree[d][ch] = tick_idx;
              if (s) begin np = 1; acc[d][ch] = tick_idx; end
              else   begin nr = 1; acc[d][ch] = -1; end
            end else if (d == 1 && e_state[d][ch] == 1 && acc[d][ch] >= 0) begin
              dd = tick_idx - acc[d][ch];
              if (dd >= RD && ((dd - RD) % RR) == 0) np = 1;
            end
          end
          e_press[d][ch] = np;
          e_rel[d][ch] = nr;
        end
      end
      for (int ch = 0; ch < NB; ch++) begin
        h2[ch] = h1[ch];
        h1[ch] = btn[ch];
      end
      n_cyc++;
    end
  end

  always @(negedge clk_25mhz) begin : compare
    for (int d = 0; d < 2; d++) begin
      for (int ch = 0; ch < NB; ch++) begin
        check($sformatf("d%0d_state%0d", d, ch), get_st(d, ch),  e_state[d][ch]);
        check($sformatf("d%0d_press%0d", d, ch), get_pr(d, ch),  e_press[d][ch]);
        check($sformatf("d%0d_rel%0d", d, ch),   get_rl(d, ch),  e_rel[d][ch]);
        check($sformatf("d%0d_cnt%0d", d, ch),   get_cnt(d, ch), e_cnt[d][ch]);
      end
    end
  end

  // which: 0 = press, 1 = release. Returns at the negedge the pulse is seen.
  task automatic wait_for(input int d, input int which, input int ch,
                          input int maxc, output int lat);
    bit seen;
    lat = 0;
    seen = 1'b0;
    while (!seen && lat < maxc) begin
      @(negedge clk_25mhz);
      lat++;
      seen = ((which == 0) ? get_pr(d, ch) : get_rl(d, ch)) != 0;
    end
    total++;
    if (!seen) begin
      bad++;
      $display("FAIL wait d%0d %s ch%0d: no pulse within %0d cycles",
               d, (which == 0) ? "press" : "release", ch, maxc);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk_25mhz);
  endtask

  task automatic press_release(input int ch);
    int lat;
    btn[ch] = 1'b1;
    wait_for(0, 0, ch, 40, lat);
    btn[ch] = 1'b0;
    wait_for(0, 1, ch, 40, lat);
    cyc(3);
  endtask

  initial begin : stim
    int lat;
    int np;
    rst_n = 1'b0;
    btn   = '0;
    clr   = '0;
    cyc(3);

    // Held press accepted after sync + 3 ticks
    rst_n = 1'b1;
    btn   = 2'b01;
    wait_for(0, 0, 0, 30, lat);
    check("t1_latency", lat, 12);
    check("t1_state0", int'(st0[0]), 1);
    cyc(1);
    check("t1_cnt0", get_cnt(0, 0), 1);
    check("t1_cnt1", get_cnt(0, 1), 0);
    check("t1_state1", int'(st0[1]), 0);
    btn = 2'b00;
    wait_for(0, 1, 0, 40, lat);
    cyc(10);

    // Short glitch, then toggling every tick
    btn[0] = 1'b1;
    cyc(5);
    btn[0] = 1'b0;
    cyc(20);
    check("t2_glitch_state", int'(st0[0]), 0);
    repeat (12) begin
      btn[0] = ~btn[0];
      cyc(DIV);
    end
    btn[0] = 1'b0;
    cyc(20);
    check("t2_toggle_state", int'(st0[0]), 0);
    check("t2_cnt", get_cnt(0, 0), 1);

    // 16 clean presses wrap the counter back to 0
    clr[0] = 1'b1;
    cyc(1);
    clr[0] = 1'b0;
    for (int k = 0; k < 16; k++) begin
      btn[0] = 1'b1;
      wait_for(0, 0, 0, 40, lat);
      cyc(1);
      check($sformatf("t3_cnt_%0d", k), get_cnt(0, 0), (k + 1) % 16);
      btn[0] = 1'b0;
      wait_for(0, 1, 0, 40, lat);
      cyc(3);
    end

    // clr beats a same-cycle press increment
    clr[0] = 1'b1;
    cyc(1);
    clr[0] = 1'b0;
    repeat (5) press_release(0);
    check("t4_cnt5", get_cnt(0, 0), 5);
    btn[0] = 1'b1;
    wait_for(0, 0, 0, 40, lat);
    clr[0] = 1'b1;
    cyc(1);
    clr[0] = 1'b0;
    check("t4_cnt_cleared", get_cnt(0, 0), 0);
    btn[0] = 1'b0;
    wait_for(0, 1, 0, 40, lat);
    btn[0] = 1'b1;
    wait_for(0, 0, 0, 40, lat);
    cyc(1);
    check("t4_cnt_after", get_cnt(0, 0), 1);
    btn[0] = 1'b0;
    wait_for(0, 1, 0, 40, lat);
    cyc(5);

    // Auto-repeat: press at tick offsets 0,2,3,...,7 within 8 ticks
    btn[0] = 1'b1;
    wait_for(1, 0, 0, 40, lat);
    np = 1;
    repeat (8 * DIV - 1) begin
      cyc(1);
      np += int'(pr1[0]);
    end
    check("t5_repeat_count", np, 7);
    btn[0] = 1'b0;
    wait_for(1, 1, 0, 60, lat);
    np = 0;
    repeat (20) begin
      cyc(1);
      np += int'(pr1[0]);
    end
    check("t5_after_release", np, 0);

    // Reset mid-filter discards the partial run
    repeat (5) press_release(0);
    check("t6_cnt7", get_cnt(0, 0), 7);
    btn[0] = 1'b1;
    cyc(9);
    rst_n = 1'b0;
    cyc(1);
    check("t6_state", int'(st0), 0);
    check("t6_press", int'(pr0), 0);
    check("t6_rel", int'(rl0), 0);
    check("t6_cnt", int'(cf0), 0);
    rst_n = 1'b1;
    wait_for(0, 0, 0, 30, lat);
    check("t6_reaccept_latency", lat, 12);
    btn[0] = 1'b0;
    wait_for(0, 1, 0, 40, lat);

    // Random traffic on both channels, sporadic clears and resets
    repeat (3000) begin
      @(negedge clk_25mhz);
      for (int ch = 0; ch < NB; ch++) begin
        if ($urandom_range(0, 11) == 0) btn[ch] = ~btn[ch];
        clr[ch] = ($urandom_range(0, 39) == 0);
      end
      rst_n = ($urandom_range(0, 599) != 0);
    end
    rst_n = 1'b1;
    clr   = '0;
    cyc(5);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
